// File: rtl/count_serial_tx_if.sv
// Request/serial-output bundle between the counter stage and the serial transmitter.
// The master drives the snapshot value and the request. The slave is the transmitter.
interface count_serial_tx_if;
    logic [7:0] count_in;
    logic       count_valid;
    logic       req_valid;
    logic       req_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [7:0] frame_cnt;

    modport master (
        output count_in, count_valid, req_valid,
        input  req_ready, tx, busy, tx_done, frame_cnt
    );

    modport slave (
        input  count_in, count_valid, req_valid,
        output req_ready, tx, busy, tx_done, frame_cnt
    );
endinterface

// File: rtl/count_serial_tx.sv
// Snapshots the 8-bit count on a valid/ready handshake and sends it as one 8N1 frame:
// a start bit, 8 data bits LSB first, then a stop bit. Completed frames are counted modulo 256.
//
//  state | meaning
//  IDLE  | line high, ready for a request when count_valid is high
//  START | start bit, line low
//  DATA  | data bits 0..7, line follows shift_q[0]
//  STOP  | stop bit, line high; tx_done is raised when this state is left
module count_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    count_serial_tx_if.slave         bus
);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, tx_d;
    logic          tx_done_q, tx_done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          accept;
    logic          baud_tc;

    // The handshake completes only in IDLE with a valid count.
    assign accept  = (state_q == IDLE) && bus.req_valid && bus.count_valid;
    assign baud_tc = (baud_q == '0);

    // Register all state. Reset leaves the line idle-high and aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            tx_done_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            tx_done_q   <= tx_done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Compute the next state and the next line level.
    // tx_d is the level for the cycle after the edge, so the line changes on the same edge as the state.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = 1'b1;
        tx_done_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = bus.count_in;
                    baud_d  = BAUD_MAX;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_tc) begin
                    baud_d    = BAUD_MAX;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_tc) begin
                    baud_d  = BAUD_MAX;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_tc) begin
                    state_d     = IDLE;
                    tx_done_d   = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == IDLE) && bus.count_valid;
    assign bus.busy      = (state_q != IDLE);
    assign bus.tx        = tx_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_count_serial_tx.sv
// Directed bench for count_serial_tx with CLKS_PER_BIT = 4.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_count_serial_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_frames = 0;
    int   pulses;

    count_serial_tx_if bus();

    count_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Start a request at the next falling edge. The request is accepted at the following rising edge.
    // The task returns at the falling edge just after that acceptance edge.
    task automatic start_req(input logic [7:0] data, input bit hold);
        @(negedge clk);
        bus.count_in  = data;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    // The task is called at the falling edge just after acceptance, and it checks all 40 frame cycles.
    // It then checks the tx_done cycle.
    task automatic check_frame(input logic [7:0] data, input bit change_mid, input string tag);
        logic [9:0] fr;
        fr = {1'b1, data, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            chk(tag, bus.tx, fr[i / CPB]);
            if (i == 20) begin
                chk("busy_mid", bus.busy, 1'b1);
                chk("ready_mid", bus.req_ready, 1'b0);
            end
            if (i == 10 * CPB - 1) chk("no_early_done", bus.tx_done, 1'b0);
            if (change_mid && i == 10) bus.count_in = 8'h00;
            @(negedge clk);
        end
        chk("tx_done", bus.tx_done, 1'b1);
        chk("busy_end", bus.busy, 1'b0);
        chk("tx_idle", bus.tx, 1'b1);
        chk("frame_cnt", bus.frame_cnt, exp_frames[7:0]);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        bus.count_in    = 8'h00;
        bus.count_valid = 1'b1;
        bus.req_valid   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // 1: reset state
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.tx_done, 1'b0);
        chk("rst_fcnt", bus.frame_cnt, 8'd0);
        chk("rst_ready", bus.req_ready, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        // 2: single frame of 0xC5
        start_req(8'hC5, 1'b0);
        exp_frames = 1;
        check_frame(8'hC5, 1'b0, "c5_bit");
        @(negedge clk);
        chk("done_one_cycle", bus.tx_done, 1'b0);

        // 3: count_valid low blocks acceptance
        bus.count_valid = 1'b0;
        bus.req_valid   = 1'b1;
        bus.count_in    = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("cv0_ready", bus.req_ready, 1'b0);
            chk("cv0_tx", bus.tx, 1'b1);
            chk("cv0_busy", bus.busy, 1'b0);
        end
        bus.count_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        exp_frames = 2;
        check_frame(8'h5A, 1'b0, "5a_bit");

        // 4: count_in changed mid-frame has no effect
        start_req(8'hC5, 1'b0);
        exp_frames = 3;
        check_frame(8'hC5, 1'b1, "snap_bit");

        // 5: back-to-back with the request held high
        @(negedge clk);
        start_req(8'hAA, 1'b1);
        exp_frames = 4;
        check_frame(8'hAA, 1'b0, "b2b1_bit");
        chk("b2b_ready", bus.req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        exp_frames = 5;
        check_frame(8'hAA, 1'b0, "b2b2_bit");

        // 6: reset during data bit 3
        start_req(8'h07, 1'b0);
        repeat (17) @(negedge clk);
        chk("pre_rst_tx", bus.tx, 1'b0);
        chk("pre_rst_busy", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", bus.tx, 1'b1);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_fcnt", bus.frame_cnt, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_done", bus.tx_done, 1'b0);
        end
        reset = 1'b0;
        start_req(8'h3C, 1'b0);
        exp_frames = 1;
        check_frame(8'h3C, 1'b0, "post_rst_bit");

        // 7: 256 frames wrap frame_cnt back to 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.count_in  = 8'h81;
        bus.req_valid = 1'b1;
        @(posedge clk);
        pulses = 0;
        for (int j = 0; j < 41 * 256; j++) begin
            @(negedge clk);
            if (bus.tx_done) pulses++;
            if (j == 41 * 256 - 1) bus.req_valid = 1'b0;
        end
        chk("wrap_pulses", pulses, 256);
        chk("wrap_fcnt", bus.frame_cnt, 8'd0);
        @(negedge clk);
        chk("wrap_busy", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
